irq_plic: RTL

IRQ_PLIC -- requirements
Module: irq_plic

---
 rtl/plic_pkg.sv | 31 +++
 rtl/plic_gateway.sv | 33 +++
 rtl/irq_plic.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/plic_pkg.sv
// Shared PLIC definitions: gateway states and the register-map layout.
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  localparam logic [23:0] PRIO_BASE   = 24'h000000;
  localparam int unsigned PRIO_STRIDE = 4;
  localparam logic [23:0] PEND_ADDR   = 24'h001000;
  localparam logic [23:0] EN_BASE     = 24'h002000;
  localparam int unsigned EN_STRIDE   = 32'h80;
  localparam logic [23:0] CTX_BASE    = 24'h200000;
  localparam int unsigned CTX_STRIDE  = 32'h1000;
  localparam int unsigned CLAIM_OFS   = 4;

  function automatic logic [23:0] prio_addr(int unsigned id);
    return 24'(PRIO_BASE + PRIO_STRIDE * id);
  endfunction

  function automatic logic [23:0] en_addr(int unsigned t);
    return 24'(EN_BASE + EN_STRIDE * t);
  endfunction

  function automatic logic [23:0] ctx_addr(int unsigned t, int unsigned ofs);
    return 24'(CTX_BASE + CTX_STRIDE * t + ofs);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Level-triggered source gateway: latches a request and holds it from claim
// until the matching completion, ignoring the line meanwhile.
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  gw_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GW_IDLE:     if (src_i) state_d = GW_PENDING;
      GW_PENDING:  if (claim_i) state_d = GW_INFLIGHT;
      GW_INFLIGHT: if (complete_i) state_d = GW_IDLE;
      default:     state_d = GW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= GW_IDLE;
    else        state_q <= state_d;
  end

  assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/irq_plic.sv
// Platform-level interrupt controller: per-source gateways, per-target
// enable/threshold, best-ID selector tree and a single-cycle register bus.
module irq_plic
  import plic_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int NUM_TGT = 1,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               bus_req,
  input  logic               bus_we,
  input  logic [23:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic               bus_ack,
  output logic [31:0]        bus_rdata,
  output logic [NUM_TGT-1:0] irq_ext
);

  localparam int IDW    = $clog2(NUM_SRC + 1);
  localparam int LEAVES = 1 << IDW;

  logic [PRIO_W-1:0]  prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [1:NUM_SRC];
  logic [NUM_SRC:1]   en_q   [NUM_TGT];
  logic [NUM_SRC:1]   en_d   [NUM_TGT];
  logic [PRIO_W-1:0]  thr_q  [NUM_TGT];
  logic [PRIO_W-1:0]  thr_d  [NUM_TGT];
  logic [NUM_TGT-1:0] irq_q, irq_d;
  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_SRC:1]   pending, claim, complete;
  logic [IDW-1:0]     best [NUM_TGT];

  for (genvar gi = 1; gi <= NUM_SRC; gi++) begin : g_gw
    plic_gateway u_gw (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_i      (src[gi-1]),
      .claim_i    (claim[gi]),
      .complete_i (complete[gi]),
      .pending_o  (pending[gi])
    );
  end

  // Ineligible leaves carry priority 0, so strict '>' keeps the left (lower) ID on ties.
  for (genvar gt = 0; gt < NUM_TGT; gt++) begin : g_sel
    logic [PRIO_W-1:0] node_prio [LEAVES];
    logic [IDW-1:0]    node_id   [LEAVES];

    always_comb begin
      for (int j = 0; j < LEAVES; j++) begin
        node_prio[j] = '0;
        node_id[j]   = '0;
      end
      for (int j = 1; j <= NUM_SRC; j++) begin
        if (pending[j] && en_q[gt][j] && (prio_q[j] > thr_q[gt])) begin
          node_prio[j] = prio_q[j];
          node_id[j]   = IDW'(j);
        end
      end
      for (int l = IDW - 1; l >= 0; l--) begin
        for (int k = 0; k < (1 << l); k++) begin
          if (node_prio[2*k+1] > node_prio[2*k]) begin
            node_prio[k] = node_prio[2*k+1];
            node_id[k]   = node_id[2*k+1];
          end else begin
            node_prio[k] = node_prio[2*k];
            node_id[k]   = node_id[2*k];
          end
        end
      end
    end

    assign best[gt]  = node_id[0];
    assign irq_d[gt] = (node_id[0] != '0);
  end

  always_comb begin
    prio_d   = prio_q;
    en_d     = en_q;
    thr_d    = thr_q;
    rdata_d  = '0;
    claim    = '0;
    complete = '0;
    if (bus_req) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (bus_addr == prio_addr(i)) begin
          if (bus_we) prio_d[i] = bus_wdata[PRIO_W-1:0];
          else        rdata_d   = 32'(prio_q[i]);
        end
      end
      if (bus_addr == PEND_ADDR && !bus_we) rdata_d = 32'({pending, 1'b0});
      for (int t = 0; t < NUM_TGT; t++) begin
        if (bus_addr == en_addr(t)) begin
          if (bus_we) en_d[t]  = bus_wdata[NUM_SRC:1];
          else        rdata_d = 32'({en_q[t], 1'b0});
        end
        if (bus_addr == ctx_addr(t, 0)) begin
          if (bus_we) thr_d[t] = bus_wdata[PRIO_W-1:0];
          else        rdata_d  = 32'(thr_q[t]);
        end
        if (bus_addr == ctx_addr(t, CLAIM_OFS)) begin
          // Completion is only honoured while the ID is still enabled for this target.
          if (bus_we) begin
            for (int i = 1; i <= NUM_SRC; i++)
              if (bus_wdata == 32'(i) && en_q[t][i]) complete[i] = 1'b1;
          end else begin
            rdata_d = 32'(best[t]);
            for (int i = 1; i <= NUM_SRC; i++)
              if (best[t] == IDW'(i)) claim[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
      for (int t = 0; t < NUM_TGT; t++) begin
        en_q[t]  <= '0;
        thr_q[t] <= '0;
      end
      irq_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      prio_q  <= prio_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      irq_q   <= irq_d;
      ack_q   <= bus_req;
      rdata_q <= rdata_d;
    end
  end

  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  assign irq_ext   = irq_q;

endmodule
